// File: rtl/rr_request_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_request_tracker
//  Description : Per-client job front-end for a 4-way round-robin arbiter.
//                Turns one-cycle job strobes into level requests held for a
//                programmed number of granted cycles, and flags bad grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_request_tracker #(
    parameter int N     = 4,
    parameter int LEN_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         client_pulse_i,
    input  logic [N*LEN_W-1:0]   client_len_i,
    input  logic [N-1:0]         grant_i,
    output logic [N-1:0]         req_o,
    output logic [N-1:0]         done_o,
    output logic [N-1:0]         ovf_o,
    output logic                 grant_err_o
);

    localparam logic [LEN_W-1:0] C_LEN_ZERO = '0;
    localparam logic [LEN_W-1:0] C_LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]     C_VEC_ONE  = {{(N-1){1'b0}}, 1'b1};

    logic [LEN_W-1:0] r_rem_q [N];
    logic [LEN_W-1:0] r_rem_d [N];
    logic [N-1:0]     r_req_q,  r_req_d;
    logic [N-1:0]     r_done_q, r_done_d;
    logic [N-1:0]     r_ovf_q,  r_ovf_d;
    logic             r_gerr_q, r_gerr_d;

    logic [LEN_W-1:0] w_len [N];
    logic [N-1:0]     w_grant_m1;
    logic             w_grant_multi;
    logic             w_grant_onehot;
    logic             w_grant_idle;
    logic [N-1:0]     w_serve;
    logic [N-1:0]     w_last;
    logic [N-1:0]     w_accept;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign w_grant_m1     = grant_i - C_VEC_ONE;
    assign w_grant_multi  = |(grant_i & w_grant_m1);
    assign w_grant_onehot = (|grant_i) & ~w_grant_multi;
    assign w_grant_idle   = |(grant_i & ~r_req_q);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_client
            assign w_len[gi]    = client_len_i[gi*LEN_W +: LEN_W];
            assign w_serve[gi]  = r_req_q[gi] & grant_i[gi] & w_grant_onehot;
            assign w_last[gi]   = w_serve[gi] & (r_rem_q[gi] == C_LEN_ONE);
            // The final service cycle frees the slot, so a strobe there is taken.
            assign w_accept[gi] = client_pulse_i[gi] & (~r_req_q[gi] | w_last[gi]);
        end
    endgenerate

    always_comb begin
        r_rem_d  = r_rem_q;
        r_req_d  = r_req_q;
        r_done_d = w_last;
        r_ovf_d  = r_ovf_q | (client_pulse_i & r_req_q & ~w_last);
        r_gerr_d = w_grant_multi | w_grant_idle;
        for (int i = 0; i < N; i++) begin
            if (w_accept[i]) begin
                r_rem_d[i] = (w_len[i] == C_LEN_ZERO) ? C_LEN_ONE : w_len[i];
                r_req_d[i] = 1'b1;
            end else if (w_serve[i]) begin
                if (r_rem_q[i] != C_LEN_ZERO) begin
                    r_rem_d[i] = r_rem_q[i] - C_LEN_ONE;
                end
                if (w_last[i]) begin
                    r_req_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_rem_q[i] <= C_LEN_ZERO;
            end
            r_req_q  <= '0;
            r_done_q <= '0;
            r_ovf_q  <= '0;
            r_gerr_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_rem_q[i] <= r_rem_d[i];
            end
            r_req_q  <= r_req_d;
            r_done_q <= r_done_d;
            r_ovf_q  <= r_ovf_d;
            r_gerr_q <= r_gerr_d;
        end
    end

    assign req_o       = r_req_q;
    assign done_o      = r_done_q;
    assign ovf_o       = r_ovf_q;
    assign grant_err_o = r_gerr_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_request_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_request_tracker
//  Description : Self-checking bench for rr_request_tracker with a cycle model
//                feeding an expected-output queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_request_tracker;

    logic        clk;
    logic        rst;
    logic [3:0]  client_pulse;
    logic [15:0] client_len;
    logic [3:0]  grant;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [3:0]  ovf;
    logic        grant_err;

    rr_request_tracker #(.N(4), .LEN_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .client_pulse_i (client_pulse),
        .client_len_i   (client_len),
        .grant_i        (grant),
        .req_o          (req),
        .done_o         (done),
        .ovf_o          (ovf),
        .grant_err_o    (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] ovf;
        logic       gerr;
    } exp_t;

    exp_t sb_q[$];

    int         n_checks = 0;
    int         n_errors = 0;

    int         m_rem [4];
    logic [3:0] m_req  = '0;
    logic [3:0] m_ovf  = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference behaviour: compute what the outputs must be after this cycle.
    function automatic exp_t model_cycle(input logic r, input logic [3:0] p,
                                         input logic [15:0] l, input logic [3:0] g);
        exp_t e;
        int   pc;
        logic served, final_svc;
        int   ln;
        e = '0;
        if (r) begin
            for (int i = 0; i < 4; i++) m_rem[i] = 0;
            m_req = '0;
            m_ovf = '0;
            return e;
        end
        pc     = $countones(g);
        e.gerr = (pc > 1) || ((g & ~m_req) != 4'b0000);
        for (int i = 0; i < 4; i++) begin
            served    = (pc == 1) && g[i] && m_req[i];
            final_svc = served && (m_rem[i] == 1);
            e.done[i] = final_svc;
            if (served) begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) m_req[i] = 1'b0;
            end
            if (p[i]) begin
                if (!m_req[i]) begin
                    ln       = int'(l[i*4 +: 4]);
                    m_rem[i] = (ln == 0) ? 1 : ln;
                    m_req[i] = 1'b1;
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end
        end
        e.req = m_req;
        e.ovf = m_ovf;
        return e;
    endfunction

    task automatic step(input logic r, input logic [3:0] p, input logic [15:0] l,
                        input logic [3:0] g);
        exp_t e;
        rst          = r;
        client_pulse = p;
        client_len   = l;
        grant        = g;
        sb_q.push_back(model_cycle(r, p, l, g));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("req",       {28'b0, req},       {28'b0, e.req});
            check("done",      {28'b0, done},      {28'b0, e.done});
            check("ovf",       {28'b0, ovf},       {28'b0, e.ovf});
            check("grant_err", {31'b0, grant_err}, {31'b0, e.gerr});
        end
    endtask

    initial begin
        logic [3:0] rg;
        for (int i = 0; i < 4; i++) m_rem[i] = 0;
        rst = 1'b1; client_pulse = '0; client_len = '0; grant = '0;

        // Reset with random inputs
        step(1'b1, 4'($urandom), 16'($urandom), 4'($urandom));
        step(1'b1, 4'($urandom), 16'($urandom), 4'($urandom));
        check("rst_outs", {19'b0, req, done, ovf, grant_err}, 32'd0);

        // Simple job, grant held
        step(1'b0, 4'b0001, 16'h0003, 4'b0000);
        check("t2_req_on", {28'b0, req}, 32'h1);
        step(1'b0, 4'b0000, 16'h0000, 4'b0001);
        step(1'b0, 4'b0000, 16'h0000, 4'b0001);
        check("t2_req_hold", {28'b0, req}, 32'h1);
        step(1'b0, 4'b0000, 16'h0000, 4'b0001);
        check("t2_done", {28'b0, done}, 32'h1);
        check("t2_req_off", {28'b0, req}, 32'h0);

        // Preemption gap
        step(1'b0, 4'b0001, 16'h0003, 4'b0000);
        step(1'b0, 4'b0000, 16'h0000, 4'b0001);
        step(1'b0, 4'b0000, 16'h0000, 4'b0000);
        step(1'b0, 4'b0000, 16'h0000, 4'b0000);
        check("t3_gap_req", {28'b0, req}, 32'h1);
        step(1'b0, 4'b0000, 16'h0000, 4'b0001);
        check("t3_no_done_yet", {28'b0, done}, 32'h0);
        step(1'b0, 4'b0000, 16'h0000, 4'b0001);
        check("t3_done", {28'b0, done}, 32'h1);

        // Overflow and same-cycle reload on client 1
        step(1'b0, 4'b0010, 16'h0050, 4'b0000);
        step(1'b0, 4'b0000, 16'h0000, 4'b0010);
        step(1'b0, 4'b0010, 16'h0070, 4'b0010);
        check("t4_ovf", {28'b0, ovf}, 32'h2);
        step(1'b0, 4'b0000, 16'h0000, 4'b0010);
        step(1'b0, 4'b0000, 16'h0000, 4'b0010);
        step(1'b0, 4'b0010, 16'h0020, 4'b0010);
        check("t4_done_reload", {28'b0, done}, 32'h2);
        check("t4_req_kept", {28'b0, req}, 32'h2);
        step(1'b0, 4'b0000, 16'h0000, 4'b0010);
        step(1'b0, 4'b0000, 16'h0000, 4'b0010);
        check("t4_done2", {28'b0, done}, 32'h2);
        check("t4_ovf_sticky", {28'b0, ovf}, 32'h2);

        // Grant protocol errors
        step(1'b0, 4'b0011, 16'h0022, 4'b0000);
        step(1'b0, 4'b0000, 16'h0000, 4'b1010);
        check("t5_multi_err", {31'b0, grant_err}, 32'h1);
        step(1'b0, 4'b0000, 16'h0000, 4'b0100);
        check("t5_idle_err", {31'b0, grant_err}, 32'h1);
        step(1'b0, 4'b0000, 16'h0000, 4'b0001);
        step(1'b0, 4'b0000, 16'h0000, 4'b0001);
        check("t5_done0", {28'b0, done}, 32'h1);
        step(1'b0, 4'b0000, 16'h0000, 4'b0010);
        step(1'b0, 4'b0000, 16'h0000, 4'b0010);
        check("t5_done1", {28'b0, done}, 32'h2);

        // Reset mid-job on client 3
        step(1'b0, 4'b1000, 16'h6000, 4'b0000);
        step(1'b0, 4'b0000, 16'h0000, 4'b1000);
        step(1'b0, 4'b0000, 16'h0000, 4'b1000);
        step(1'b1, 4'b0000, 16'h0000, 4'b0000);
        check("t6_rst_req", {28'b0, req}, 32'h0);
        check("t6_rst_ovf", {28'b0, ovf}, 32'h0);
        step(1'b0, 4'b0000, 16'h0000, 4'b0000);
        check("t6_no_done", {28'b0, done}, 32'h0);
        step(1'b0, 4'b1000, 16'h0000, 4'b0000);
        step(1'b0, 4'b0000, 16'h0000, 4'b1000);
        check("t6_len0_done", {28'b0, done}, 32'h8);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 9))
                0:       rg = 4'($urandom);
                1, 2:    rg = 4'b0000;
                default: rg = 4'b0001 << $urandom_range(0, 3);
            endcase
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                 16'($urandom), rg);
        end

        check("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
